// File: rtl/gsim_pkg.sv
// Shared constants for the GSIM matrix-memory blocks.
package gsim_pkg;
  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 256;
  localparam int WORD_W   = 16;
  localparam int X_ADDR_W = 9;
  localparam int X_DATA_W = 32;
  localparam int ROWS     = 1 << ADDR_W;
endpackage

// File: rtl/gsim_mem_resp_if.sv
// Read-request / response and preload bundle between a matrix-memory initiator and gsim_mem_resp.
interface gsim_mem_resp_if;
  import gsim_pkg::*;

  logic              i_mem_rreq;
  logic [ADDR_W-1:0] i_mem_addr;
  logic              o_mem_rrdy;
  logic [DATA_W-1:0] o_mem_dout;
  logic              o_mem_dout_vld;
  logic              i_ld_wen;
  logic [ADDR_W-1:0] i_ld_addr;
  logic [DATA_W-1:0] i_ld_data;

  modport master (
    output i_mem_rreq, i_mem_addr, i_ld_wen, i_ld_addr, i_ld_data,
    input  o_mem_rrdy, o_mem_dout, o_mem_dout_vld
  );

  modport slave (
    input  i_mem_rreq, i_mem_addr, i_ld_wen, i_ld_addr, i_ld_data,
    output o_mem_rrdy, o_mem_dout, o_mem_dout_vld
  );
endinterface

// File: rtl/gsim_mem_sram.sv
// 1024 x 256 row array: one write port, synchronous one-cycle read with resettable output register.
module gsim_mem_sram
  import gsim_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wen_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              ren_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [ROWS];
  logic [DATA_W-1:0] rdata_q;

  // Row contents survive reset; only the read register is cleared.
  always_ff @(posedge clk_i) begin
    if (wen_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)      rdata_q <= '0;
    else if (ren_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/gsim_mem_resp.sv
// Fixed-latency, in-order matrix-memory read responder with outstanding-read limit.
// Optional periodic stall injection enabled by defining GSIM_MEM_STALL_EN.
module gsim_mem_resp
  import gsim_pkg::*;
#(
  parameter int LATENCY      = 2,
  parameter int MAX_OUT      = 2,
  parameter int STALL_PERIOD = 8
) (
  input  logic            i_clk,
  input  logic            i_reset,
  gsim_mem_resp_if.slave  mem
);
  localparam int CNT_W = 3;

  if (LATENCY < 1 || LATENCY > 4 || MAX_OUT < 1 || MAX_OUT > 4 ||
      STALL_PERIOD < 2 || STALL_PERIOD > 16) begin : g_param_chk
    $error("gsim_mem_resp: parameter out of legal range");
  end

  logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
  logic [LATENCY-1:0] vld_q;
  logic               stall;
  logic               rrdy;
  logic               accept;
  logic               resp_vld;
  logic [DATA_W-1:0]  sram_rdata;

  // Ready is a function of registered state and the preload strobe only.
  assign rrdy     = !i_reset && !mem.i_ld_wen && (out_cnt_q < CNT_W'(MAX_OUT)) && !stall;
  assign accept   = mem.i_mem_rreq && rrdy;
  assign resp_vld = vld_q[LATENCY-1];

  assign mem.o_mem_rrdy     = rrdy;
  assign mem.o_mem_dout_vld = resp_vld && !i_reset;

  always_comb begin
    out_cnt_d = out_cnt_q;
    if (accept && !resp_vld)      out_cnt_d = out_cnt_q + CNT_W'(1);
    else if (!accept && resp_vld) out_cnt_d = out_cnt_q - CNT_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      out_cnt_q <= '0;
      vld_q     <= '0;
    end else begin
      out_cnt_q <= out_cnt_d;
      vld_q[0]  <= accept;
      for (int i = 1; i < LATENCY; i++) vld_q[i] <= vld_q[i-1];
    end
  end

`ifdef GSIM_MEM_STALL_EN
  localparam int SC_W = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
  logic [SC_W-1:0] stall_cnt_q, stall_cnt_d;

  assign stall       = (stall_cnt_q == SC_W'(STALL_PERIOD - 1));
  assign stall_cnt_d = stall ? '0 : stall_cnt_q + SC_W'(1);

  always_ff @(posedge i_clk) begin
    if (i_reset) stall_cnt_q <= '0;
    else         stall_cnt_q <= stall_cnt_d;
  end
`else
  assign stall = 1'b0;
`endif

  gsim_mem_sram u_sram (
    .clk_i   (i_clk),
    .rst_i   (i_reset),
    .wen_i   (mem.i_ld_wen),
    .waddr_i (mem.i_ld_addr),
    .wdata_i (mem.i_ld_data),
    .ren_i   (accept),
    .raddr_i (mem.i_mem_addr),
    .rdata_o (sram_rdata)
  );

  // The array supplies stage 1; stages 2..LATENCY are registers here.
  if (LATENCY == 1) begin : g_lat1
    assign mem.o_mem_dout = sram_rdata;
  end else begin : g_latn
    logic [DATA_W-1:0] pre_data;
    logic [DATA_W-1:0] dout_q;

    if (LATENCY >= 3) begin : g_mid
      logic [DATA_W-1:0] mid_q [LATENCY-2];
      always_ff @(posedge i_clk) begin
        mid_q[0] <= sram_rdata;
        for (int i = 1; i < LATENCY - 2; i++) mid_q[i] <= mid_q[i-1];
      end
      assign pre_data = mid_q[LATENCY-3];
    end else begin : g_nomid
      assign pre_data = sram_rdata;
    end

    // Output register only loads on a valid response, so it holds between strobes.
    always_ff @(posedge i_clk) begin
      if (i_reset)                 dout_q <= '0;
      else if (vld_q[LATENCY-2])   dout_q <= pre_data;
    end
    assign mem.o_mem_dout = dout_q;
  end
endmodule
